// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Limits and constant functions that build the KMP next-state
//            table for param_sequence_detector.
// Revision : 1.0  initial release
// ============================================================================
package seq_det_pkg;

    localparam int SEQ_DET_MAX_LEN   = 16;
    localparam int SEQ_DET_MAX_CNT_W = 32;
    localparam int SEQ_DET_IDX_W     = 4;

    // i-th bit in arrival order (pattern is MSB first)
    function automatic logic seq_det_bit_f(input logic [SEQ_DET_MAX_LEN-1:0] pattern,
                                           input int len, input int i);
        return pattern[SEQ_DET_IDX_W'(len - 1 - i)];
    endfunction

    function automatic int seq_det_fail_f(input logic [SEQ_DET_MAX_LEN-1:0] pattern,
                                          input int len, input int idx);
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < idx; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (seq_det_bit_f(pattern, len, j) != seq_det_bit_f(pattern, len, idx - k + j))
                    ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    function automatic int seq_det_next_f(input logic [SEQ_DET_MAX_LEN-1:0] pattern,
                                          input int len, input int st,
                                          input logic bit_in, input logic overlap);
        logic [SEQ_DET_MAX_LEN-1:0] s;
        int   n;
        int   res;
        logic ok;
        s = '0;
        for (int i = 0; i < st; i++)
            s[SEQ_DET_IDX_W'(i)] = seq_det_bit_f(pattern, len, i);
        s[SEQ_DET_IDX_W'(st)] = bit_in;
        n = st + 1;
        if (n == len && bit_in == seq_det_bit_f(pattern, len, st))
            return overlap ? seq_det_fail_f(pattern, len, len) : 0;
        res = 0;
        for (int k = 1; k <= n; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (s[SEQ_DET_IDX_W'(n - k + j)] != seq_det_bit_f(pattern, len, j))
                        ok = 1'b0;
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_sat_counter
// Purpose  : Saturating event counter with synchronous clear.
// Revision : 1.0  initial release
// ============================================================================
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/param_sequence_detector.sv
`default_nettype none
// ============================================================================
// Module   : param_sequence_detector
// Purpose  : Parametrised serial pattern detector (KMP automaton); the match
//            counter exists only when PARAM_SEQ_DET_COUNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module param_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int               SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b0110,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             data_in,
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    localparam int c_st_w  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int c_tbl_n = 2 ** (c_st_w + 1);
    localparam logic [SEQ_DET_MAX_LEN-1:0] c_pat = SEQ_DET_MAX_LEN'(PATTERN);

    if (SEQ_LEN < 2 || SEQ_LEN > SEQ_DET_MAX_LEN) begin : g_bad_len
        $error("param_sequence_detector: SEQ_LEN out of range 2..16");
    end
    if (CNT_W < 1 || CNT_W > SEQ_DET_MAX_CNT_W) begin : g_bad_cnt_w
        $error("param_sequence_detector: CNT_W out of range 1..32");
    end

    logic [c_st_w-1:0] w_next_tbl [c_tbl_n];
    logic [c_st_w-1:0] r_st;
    logic [c_st_w-1:0] w_st_next;
    logic              r_detected;
    logic              w_complete;
    logic              w_inc;

    // Table entry {state, bit}; rows beyond SEQ_LEN-1 are unreachable.
    for (genvar gi = 0; gi < c_tbl_n; gi++) begin : g_tbl
        if ((gi / 2) < SEQ_LEN) begin : g_live
            assign w_next_tbl[gi] = c_st_w'(seq_det_next_f(c_pat, SEQ_LEN, gi / 2,
                                                           (gi % 2) == 1, OVERLAP != 0));
        end else begin : g_pad
            assign w_next_tbl[gi] = '0;
        end
    end

    assign w_complete = (r_st == c_st_w'(SEQ_LEN - 1)) && (data_in == PATTERN[0]);
    assign w_inc      = en && !clear && w_complete;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st       <= '0;
            r_detected <= 1'b0;
        end else begin
            r_st       <= w_st_next;
            r_detected <= w_inc;
        end
    end

    always_comb begin
        w_st_next = r_st;
        if (clear) begin
            w_st_next = '0;
        end else if (en) begin
            w_st_next = w_next_tbl[{r_st, data_in}];
        end
    end

    assign detected = r_detected;

`ifdef PARAM_SEQ_DET_COUNT_EN
    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (w_inc),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_sequence_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_sequence_detector
// Purpose  : Self-checking bench: four detector configurations against a
//            history-window reference model, directed plus random stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_param_sequence_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic en = 1'b0;
    logic data_in = 1'b0;

    logic       det_a, det_b, det_c, det_d;
    logic [7:0] cnt_a, cnt_b, cnt_d;
    logic [1:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: 0110 overlap; b: 0110 non-overlap; c: 1111 overlap, 2-bit count; d: 1111 non-overlap
    param_sequence_detector #(.SEQ_LEN(4), .PATTERN(4'b0110), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data_in(data_in),
        .detected(det_a), .match_count(cnt_a));
    param_sequence_detector #(.SEQ_LEN(4), .PATTERN(4'b0110), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data_in(data_in),
        .detected(det_b), .match_count(cnt_b));
    param_sequence_detector #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data_in(data_in),
        .detected(det_c), .match_count(cnt_c));
    param_sequence_detector #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(0), .CNT_W(8)) dut_d (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .data_in(data_in),
        .detected(det_d), .match_count(cnt_d));

    logic obs_det [4];
    int   obs_cnt [4];
    assign obs_det[0] = det_a;
    assign obs_det[1] = det_b;
    assign obs_det[2] = det_c;
    assign obs_det[3] = det_d;
    assign obs_cnt[0] = 32'(cnt_a);
    assign obs_cnt[1] = 32'(cnt_b);
    assign obs_cnt[2] = 32'(cnt_c);
    assign obs_cnt[3] = 32'(cnt_d);

    // Model: detection = the last 4 accepted bits equal the pattern; a
    // non-overlapping match forgets the history it consumed.
    logic [3:0]  m_pat  [4] = '{4'b0110, 4'b0110, 4'b1111, 4'b1111};
    bit          m_ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int          m_max  [4] = '{255, 255, 3, 255};
    logic [15:0] m_hist [4];
    int          m_hlen [4];
    bit          m_det  [4];
    int          m_cnt  [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_hist[k] = '0;
            m_hlen[k] = 0;
            m_det[k]  = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic model_step(input logic c, input logic e, input logic d);
        for (int k = 0; k < 4; k++) begin
            m_det[k] = 1'b0;
            if (c) begin
                m_hist[k] = '0;
                m_hlen[k] = 0;
                m_cnt[k]  = 0;
            end else if (e) begin
                m_hist[k] = {m_hist[k][14:0], d};
                if (m_hlen[k] < 16) m_hlen[k]++;
                if (m_hlen[k] >= 4 && m_hist[k][3:0] == m_pat[k]) begin
                    m_det[k] = 1'b1;
                    if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                    if (!m_ov[k]) m_hlen[k] = 0;
                end
            end
        end
    endtask

    function automatic int exp_cnt(input int k);
`ifdef PARAM_SEQ_DET_COUNT_EN
        return m_cnt[k];
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            checks++;
            assert (obs_det[k] === m_det[k]) else begin
                errors++;
                $error("FAIL %s det[%0d] observed=%0b expected=%0b", tag, k, obs_det[k], m_det[k]);
            end
            checks++;
            assert (obs_cnt[k] === exp_cnt(k)) else begin
                errors++;
                $error("FAIL %s cnt[%0d] observed=%0d expected=%0d", tag, k, obs_cnt[k], exp_cnt(k));
            end
        end
    endtask

    task automatic step(input logic c, input logic e, input logic d, input string tag);
        @(negedge clk);
        clear   = c;
        en      = e;
        data_in = d;
        @(posedge clk);
        model_step(c, e, d);
        #1;
        check_all(tag);
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], tag);
    endtask

    task automatic do_clear(input string tag);
        step(1'b1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // 0110 after reset: one pulse on the 4th edge
        feed(16'b0110, 4, "s1");
        checks++;
        assert (det_a === 1'b1) else begin
            errors++;
            $error("FAIL s1_pulse observed=%0b expected=1", det_a);
        end
        step(1'b0, 1'b0, 1'b0, "s1_idle");
        do_clear("clr");

        // 0110110: overlapping gives two pulses, non-overlapping one
        feed(16'b0110110, 7, "s2");
        do_clear("clr");

        // six 1s
        feed(16'b111111, 6, "s3");
        checks++;
        assert (det_c === 1'b1 && det_d === 1'b0) else begin
            errors++;
            $error("FAIL s3_last observed=%0b%0b expected=10", det_c, det_d);
        end
        do_clear("clr");

        // progress survives an en gap
        feed(16'b01, 2, "s4");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i[0], "s4_gap");
        feed(16'b10, 2, "s4_end");
        checks++;
        assert (det_a === 1'b1) else begin
            errors++;
            $error("FAIL s4_pulse observed=%0b expected=1", det_a);
        end
        do_clear("clr");

        // saturation of the 2-bit counter, then clear
        for (int i = 0; i < 10; i++) feed(16'b1111, 4, "s5_sat");
        feed(16'b0110, 4, "s5_ov");
        feed(16'b110, 3, "s5_ov");
        do_clear("s5_clr");
        feed(16'b110, 3, "s5_after");
        feed(16'b0110, 4, "s5_full");

        // async reset between 011 and the final 0
        do_clear("clr");
        feed(16'b011, 3, "s6");
        @(negedge clk);
        en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("s6_async");
        @(negedge clk);
        reset = 1'b1;
        feed(16'b0, 1, "s6_tail");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
                 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
